// File: rtl/mux_arb_n_if.sv
// Handshake bundle for mux_arb_n: N producer channels in, one registered consumer channel out.
// The slave modport is the mux's view and the master modport is the environment's view.
interface mux_arb_n_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int SELW = $clog2(N);

  logic              mode_rr;
  logic [SELW-1:0]   sel;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_ready;
  logic [WIDTH-1:0]  out_data;
  logic [SELW-1:0]   out_src;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       stall_cnt;

  modport slave (
    input  mode_rr, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_src, out_valid, stall_cnt
  );

  modport master (
    output mode_rr, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_src, out_valid, stall_cnt
  );
endinterface

// File: rtl/mux_arb_n.sv
// N-way valid/ready multiplexer with a single registered output stage, steered by sel or round-robin arbitrated.
// Optional output-stall counter enabled by defining MUX_ARB_STATS_EN.
module mux_arb_n #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic       clk,
  input  logic       rst,
  mux_arb_n_if.slave bus
);
  localparam int SELW = $clog2(N);

  logic             load_en_s;
  logic             grant_s;
  logic [SELW-1:0]  g_s;
  logic [SELW:0]    idx_s;
  logic [N-1:0]     in_ready_s;
  logic [WIDTH-1:0] out_data_r;
  logic [SELW-1:0]  out_src_r;
  logic             out_valid_r;
  logic [SELW-1:0]  rr_ptr_r;

  assign load_en_s = !out_valid_r || bus.out_ready;

  // Grant selection: steered by sel, or first valid channel scanning from rr_ptr with wrap
  always_comb begin
    grant_s = 1'b0;
    g_s     = '0;
    idx_s   = '0;
    if (bus.mode_rr) begin
      for (int k = 0; k < N; k++) begin
        idx_s = {1'b0, rr_ptr_r} + (SELW+1)'(k);
        if (idx_s >= (SELW+1)'(N)) begin
          idx_s = idx_s - (SELW+1)'(N);
        end else begin
          idx_s = idx_s;
        end
        if (!grant_s && bus.in_valid[idx_s[SELW-1:0]]) begin
          grant_s = 1'b1;
          g_s     = idx_s[SELW-1:0];
        end else begin
          grant_s = grant_s;
        end
      end
    end else begin
      // sel values beyond N-1 exist only for non-power-of-2 N and never grant
      if (({1'b0, bus.sel} < (SELW+1)'(N)) && bus.in_valid[bus.sel]) begin
        grant_s = 1'b1;
        g_s     = bus.sel;
      end else begin
        grant_s = 1'b0;
      end
    end
  end

  // One-hot ready towards the granted channel, only when the output register can load
  always_comb begin
    in_ready_s = '0;
    if (grant_s && load_en_s && !rst) begin
      in_ready_s[g_s] = 1'b1;
    end else begin
      in_ready_s = '0;
    end
  end

  assign bus.in_ready = in_ready_s;

  // Output register and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_r  <= '0;
      out_src_r   <= '0;
      out_valid_r <= 1'b0;
      rr_ptr_r    <= '0;
    end else if (load_en_s) begin
      if (grant_s) begin
        out_data_r  <= bus.in_data[int'(g_s)*WIDTH +: WIDTH];
        out_src_r   <= g_s;
        out_valid_r <= 1'b1;
        rr_ptr_r    <= (g_s == SELW'(N-1)) ? '0 : g_s + SELW'(1);
      end else begin
        out_valid_r <= 1'b0;
      end
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.out_data  = out_data_r;
  assign bus.out_src   = out_src_r;
  assign bus.out_valid = out_valid_r;

`ifdef MUX_ARB_STATS_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of cycles where a valid word waits on the consumer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 16'h0000;
    end else if (out_valid_r && !bus.out_ready && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.stall_cnt = stall_cnt_r;
`else
  assign bus.stall_cnt = 16'h0000;
`endif
endmodule
